// File: rtl/secp256k1_pkg.sv
// Shared secp256k1 field constants, Jacobian point payload and point-doubling sequencer types.
package secp256k1_pkg;

  localparam int unsigned W = 256;
  localparam logic [W-1:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
  } jb_point_t;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ADD, DONE} dbl_state_e;

  typedef logic [2:0] dbl_step_t;
  typedef logic [1:0] dbl_add_t;

  function automatic logic is_inf(input jb_point_t pt);
    return pt.z == '0;
  endfunction

  // ADD cycles that follow the multiplier capture of each doubling step
  function automatic dbl_add_t dbl_add_count(input dbl_step_t s);
    case (s)
      3'd2:    return 2'd2;
      3'd3:    return 2'd1;
      3'd4:    return 2'd2;
      3'd5:    return 2'd3;
      3'd6:    return 2'd2;
      3'd7:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/secp256k1_mod_addsub.sv
// Combinational modular adder/subtractor; operands must already be reduced below P.
module secp256k1_mod_addsub
  import secp256k1_pkg::*;
#(
  parameter logic [W-1:0] P = secp256k1_pkg::P
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] res_c_o
);

  logic [W:0] sum, sum_red, dif, dif_fix;

  assign sum     = {1'b0, a_i} + {1'b0, b_i};
  assign sum_red = sum - {1'b0, P};
  assign dif     = {1'b0, a_i} - {1'b0, b_i};
  assign dif_fix = dif + {1'b0, P};

  // sum_red borrows when sum < P; dif borrows when a < b
  assign res_c_o = sub_i ? (dif[W] ? dif_fix[W-1:0] : dif[W-1:0])
                         : (sum_red[W] ? sum[W-1:0] : sum_red[W-1:0]);

endmodule

// File: rtl/secp256k1_point_dbl.sv
// Jacobian point doubling (a = 0) over secp256k1, sharing one external modular multiplier.
module secp256k1_point_dbl
  import secp256k1_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  jb_point_t    i_p,
  input  logic         i_p_val,
  output logic         o_p_rdy,
  output jb_point_t    o_p,
  output logic         o_p_val,
  input  logic         i_p_rdy,
  output logic [W-1:0] o_mul_a,
  output logic [W-1:0] o_mul_b,
  output logic         o_mul_val,
  input  logic         i_mul_rdy,
  input  logic [W-1:0] i_mul_c,
  input  logic         i_mul_val
);

  dbl_state_e   state_q;
  dbl_step_t    step_q, iss_step;
  dbl_add_t     add_q;
  logic [W-1:0] x_q, y_q, z_q, a_q, d_q, b_q, c_q, m_q;
  logic [W-1:0] xo_q, yo_q, zo_q;
  logic [W-1:0] mul_a_q, mul_b_q;
  logic         mul_val_q, p_val_q, p_rdy_q;
  jb_point_t    p_q;
  logic [W-1:0] as_a, as_b, as_r, iss_a, iss_b;
  logic         as_sub;

  assign o_p_rdy   = p_rdy_q;
  assign o_p       = p_q;
  assign o_p_val   = p_val_q;
  assign o_mul_a   = mul_a_q;
  assign o_mul_b   = mul_b_q;
  assign o_mul_val = mul_val_q;

  // Adder operand select; m_q holds the latest multiplier product (or T in step 7)
  always_comb begin
    as_a   = m_q;
    as_b   = m_q;
    as_sub = 1'b0;
    case (step_q)
      3'd2: if (add_q == 2'd1) as_a = d_q;
      3'd4: if (add_q == 2'd1) begin as_a = b_q; as_b = b_q; end
      3'd5: if (add_q != 2'd0) begin as_a = c_q; as_b = c_q; end
      3'd6: begin
        as_sub = 1'b1;
        as_b   = b_q;
        if (add_q == 2'd1) as_a = xo_q;
      end
      3'd7: begin
        as_sub = 1'b1;
        if (add_q == 2'd0) begin as_a = b_q; as_b = xo_q; end
        else               begin as_a = m_q; as_b = c_q;  end
      end
      default: ;
    endcase
  end

  secp256k1_mod_addsub #(.P(P)) u_addsub (
    .a_i    (as_a),
    .b_i    (as_b),
    .sub_i  (as_sub),
    .res_c_o(as_r)
  );

  // Operands for the next multiply; step 7 takes T straight from the adder
  always_comb begin
    iss_step = (state_q == ADD && step_q == 3'd7) ? 3'd7 : step_q + 3'd1;
    iss_a    = y_q;
    iss_b    = y_q;
    case (iss_step)
      3'd2: begin iss_a = x_q; iss_b = x_q; end
      3'd3: begin iss_a = y_q; iss_b = z_q; end
      3'd4: begin iss_a = x_q; iss_b = a_q; end
      3'd5: begin iss_a = a_q; iss_b = a_q; end
      3'd6: begin iss_a = d_q; iss_b = d_q; end
      3'd7: begin iss_a = d_q; iss_b = as_r; end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      step_q    <= '0;
      add_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      a_q       <= '0;
      d_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      m_q       <= '0;
      xo_q      <= '0;
      yo_q      <= '0;
      zo_q      <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_val_q <= 1'b0;
      p_q       <= '0;
      p_val_q   <= 1'b0;
      p_rdy_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_p_val) begin
            x_q     <= i_p.x;
            y_q     <= i_p.y;
            z_q     <= i_p.z;
            p_rdy_q <= 1'b0;
            if (is_inf(i_p)) begin
              xo_q    <= i_p.x;
              yo_q    <= i_p.y;
              zo_q    <= i_p.z;
              state_q <= DONE;
            end else begin
              step_q    <= 3'd1;
              add_q     <= '0;
              mul_a_q   <= i_p.y;
              mul_b_q   <= i_p.y;
              mul_val_q <= 1'b1;
              state_q   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (i_mul_rdy) begin
            mul_val_q <= 1'b0;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (i_mul_val) begin
            m_q <= i_mul_c;
            if (step_q == 3'd1) begin
              a_q       <= i_mul_c;
              step_q    <= 3'd2;
              mul_a_q   <= iss_a;
              mul_b_q   <= iss_b;
              mul_val_q <= 1'b1;
              state_q   <= ISSUE;
            end else begin
              add_q   <= (step_q == 3'd7) ? 2'd1 : 2'd0;
              state_q <= ADD;
            end
          end
        end
        ADD: begin
          case (step_q)
            3'd2:    d_q  <= as_r;
            3'd3:    zo_q <= as_r;
            3'd4:    b_q  <= as_r;
            3'd5:    c_q  <= as_r;
            3'd6:    xo_q <= as_r;
            default: if (add_q == 2'd0) m_q <= as_r; else yo_q <= as_r;
          endcase
          if (step_q == 3'd7) begin
            if (add_q == 2'd0) begin
              mul_a_q   <= iss_a;
              mul_b_q   <= iss_b;
              mul_val_q <= 1'b1;
              state_q   <= ISSUE;
            end else begin
              state_q <= DONE;
            end
          end else if (add_q == dbl_add_count(step_q) - 2'd1) begin
            add_q <= '0;
            if (step_q == 3'd6) begin
              step_q <= 3'd7;
            end else begin
              step_q    <= step_q + 3'd1;
              mul_a_q   <= iss_a;
              mul_b_q   <= iss_b;
              mul_val_q <= 1'b1;
              state_q   <= ISSUE;
            end
          end else begin
            add_q <= add_q + 2'd1;
          end
        end
        DONE: begin
          if (!p_val_q) begin
            p_q     <= '{x: xo_q, y: yo_q, z: zo_q};
            p_val_q <= 1'b1;
          end else if (i_p_rdy) begin
            p_val_q <= 1'b0;
            p_rdy_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_secp256k1_point_dbl.sv
// Self-checking bench for secp256k1_point_dbl against a formula-level Jacobian doubling model.
module tb_secp256k1_point_dbl;
  import secp256k1_pkg::*;

  localparam logic [255:0] GX = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [255:0] GY = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
  localparam logic [255:0] G2X = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
  localparam logic [255:0] G2Y = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;

  logic         i_clk = 1'b0;
  logic         i_rst;
  jb_point_t    i_p;
  logic         i_p_val;
  logic         o_p_rdy;
  jb_point_t    o_p;
  logic         o_p_val;
  logic         i_p_rdy;
  logic [255:0] o_mul_a, o_mul_b;
  logic         o_mul_val;
  logic         i_mul_rdy;
  logic [255:0] i_mul_c;
  logic         i_mul_val;

  logic [255:0] u_a, u_b, u_r;
  logic         u_sub;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  secp256k1_point_dbl dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_p      (i_p),
    .i_p_val  (i_p_val),
    .o_p_rdy  (o_p_rdy),
    .o_p      (o_p),
    .o_p_val  (o_p_val),
    .i_p_rdy  (i_p_rdy),
    .o_mul_a  (o_mul_a),
    .o_mul_b  (o_mul_b),
    .o_mul_val(o_mul_val),
    .i_mul_rdy(i_mul_rdy),
    .i_mul_c  (i_mul_c),
    .i_mul_val(i_mul_val)
  );

  secp256k1_mod_addsub u_unit (
    .a_i    (u_a),
    .b_i    (u_b),
    .sub_i  (u_sub),
    .res_c_o(u_r)
  );

  task automatic check(input string name, input logic [767:0] act, input logic [767:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mulm(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] t;
    t = {256'd0, a} * {256'd0, b};
    t = t % {256'd0, P};
    return t[255:0];
  endfunction

  function automatic logic [255:0] addm(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] s;
    s = {1'b0, a} + {1'b0, b};
    s = s % {1'b0, P};
    return s[255:0];
  endfunction

  function automatic logic [255:0] subm(input logic [255:0] a, input logic [255:0] b);
    return addm(a, P - b);
  endfunction

  function automatic logic [255:0] powm(input logic [255:0] b, input logic [255:0] e);
    logic [255:0] r;
    r = 256'd1;
    for (int i = 255; i >= 0; i--) begin
      r = mulm(r, r);
      if (e[i]) r = mulm(r, b);
    end
    return r;
  endfunction

  // Textbook a=0 Jacobian doubling, written with scalar multiples
  function automatic jb_point_t dbl_ref(input jb_point_t pt);
    jb_point_t    r;
    logic [255:0] a, b, c, d;
    if (pt.z == 256'd0) return pt;
    a   = mulm(pt.y, pt.y);
    b   = mulm(256'd4, mulm(pt.x, a));
    c   = mulm(256'd8, mulm(a, a));
    d   = mulm(256'd3, mulm(pt.x, pt.x));
    r.x = subm(mulm(d, d), mulm(256'd2, b));
    r.y = subm(mulm(d, subm(b, r.x)), c);
    r.z = mulm(256'd2, mulm(pt.y, pt.z));
    return r;
  endfunction

  function automatic logic [255:0] rand_coord();
    logic [255:0] r;
    case ($urandom_range(0, 3))
      0: r = P - 256'd1;
      1: r = P - 256'd2;
      2: begin
        r = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        if (r >= P) r = r - P;
      end
      default: r = 256'($urandom_range(1, 1000));
    endcase
    return r;
  endfunction

  // Multiplier model; only this process drives the multiplier-side inputs
  int  lmin = 3, lmax = 3;
  bit  rdy_rand = 1'b0;
  int  req_cnt = 0;
  int  mv_cnt = 0;
  int  stale_req = 0;
  int  stale_done = 0;

  initial begin
    logic [255:0] ra, rb, ha, hb;
    bit           hv, ab;
    int           lat;
    hv        = 1'b0;
    i_mul_rdy = 1'b1;
    i_mul_val = 1'b0;
    i_mul_c   = '0;
    forever begin
      @(negedge i_clk);
      i_mul_val = 1'b0;
      if (stale_done != stale_req) begin
        i_mul_val  = 1'b1;
        i_mul_c    = {$urandom(), $urandom(), $urandom(), $urandom(),
                      $urandom(), $urandom(), $urandom(), $urandom()};
        stale_done = stale_req;
      end
      i_mul_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_mul_val) mv_cnt++;
      if (hv && o_mul_val) check("mul_ops_stable", 768'({o_mul_a, o_mul_b}), 768'({ha, hb}));
      hv = o_mul_val && !i_mul_rdy;
      ha = o_mul_a;
      hb = o_mul_b;
      if (o_mul_val && i_mul_rdy && !i_rst) begin
        req_cnt++;
        hv  = 1'b0;
        ra  = o_mul_a;
        rb  = o_mul_b;
        ab  = 1'b0;
        lat = int'($urandom_range(lmin, lmax));
        repeat (lat) begin
          @(negedge i_clk);
          i_mul_val = 1'b0;
          if (i_rst) ab = 1'b1;
        end
        if (!ab) begin
          i_mul_val = 1'b1;
          i_mul_c   = mulm(ra, rb);
        end
      end
    end
  end

  task automatic run_job(input jb_point_t pin, input int hold, output jb_point_t pout,
                         output int lat, output int muls, output int mvs);
    int k, base_r, base_m;
    @(negedge i_clk);
    k = 0;
    while (!o_p_rdy && k < 200) begin @(negedge i_clk); k++; end
    if (!o_p_rdy) check("p_rdy_wait", 768'(o_p_rdy), 768'(1));
    base_r  = req_cnt;
    base_m  = mv_cnt;
    i_p_rdy = (hold == 0);
    i_p     = pin;
    i_p_val = 1'b1;
    @(negedge i_clk);
    i_p_val = 1'b0;
    k = 0;
    while (!o_p_val && k < 3000) begin @(negedge i_clk); k++; end
    if (!o_p_val) check("done_wait", 768'(o_p_val), 768'(1));
    lat  = k;
    pout = o_p;
    repeat (hold) begin
      @(negedge i_clk);
      check("p_hold", 768'({o_p_val, o_p}), 768'({1'b1, pout}));
    end
    i_p_rdy = 1'b1;
    @(negedge i_clk);
    check("val_drop", 768'(o_p_val), 768'(0));
    muls = req_cnt - base_r;
    mvs  = mv_cnt - base_m;
  endtask

  typedef struct {
    jb_point_t pin;
    jb_point_t exp;
    int        lat;
    int        muls;
  } vec_t;

  initial begin
    vec_t         vt[5];
    jb_point_t    g, res, gres;
    int           lat, muls, mvs, k, base_r;
    logic [255:0] zi, zi2;

    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vt[5];
    jb_point_t    g, res, gres;
    int           lat, muls, mvs, k, base_r;
    logic [255:0] zi, zi2;

    i_rst   = 1'b1;
    i_p     = '0;
    i_p_val = 1'b0;
    i_p_rdy = 1'b1;
    u_a = '0; u_b = '0; u_sub = 1'b0;
    g = '{x: GX, y: GY, z: 256'd1};

    repeat (3) @(negedge i_clk);
    check("rst_flags", 768'({o_p_val, o_mul_val, o_p_rdy}), 768'(3'b001));
    check("rst_p", 768'(o_p), 768'(0));
    check("rst_mul_ops", 768'({o_mul_a, o_mul_b}), 768'(0));
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rdy_after_rst", 768'(o_p_rdy), 768'(1));

    vt[0] = '{pin: g, exp: dbl_ref(g), lat: 41, muls: 7};
    vt[1] = '{pin: '{x: 256'd5, y: 256'd9, z: 256'd0},
              exp: '{x: 256'd5, y: 256'd9, z: 256'd0}, lat: 1, muls: 0};
    vt[2] = '{pin: '{x: GX, y: 256'd0, z: 256'd1},
              exp: dbl_ref('{x: GX, y: 256'd0, z: 256'd1}), lat: 41, muls: 7};
    vt[3] = '{pin: '{x: P - 256'd1, y: P - 256'd1, z: P - 256'd1},
              exp: dbl_ref('{x: P - 256'd1, y: P - 256'd1, z: P - 256'd1}), lat: 41, muls: 7};
    vt[4] = '{pin: '{x: P - 256'd2, y: P - 256'd1, z: 256'd1},
              exp: dbl_ref('{x: P - 256'd2, y: P - 256'd1, z: 256'd1}), lat: 41, muls: 7};

    for (int i = 0; i < 5; i++) begin
      run_job(vt[i].pin, 0, res, lat, muls, mvs);
      check($sformatf("vec%0d_p", i), 768'(res), 768'(vt[i].exp));
      check($sformatf("vec%0d_lat", i), 768'(lat), 768'(vt[i].lat));
      check($sformatf("vec%0d_muls", i), 768'(muls), 768'(vt[i].muls));
      if (vt[i].muls == 0) check($sformatf("vec%0d_mulval", i), 768'(mvs), 768'(0));
      if (i == 0) gres = res;
      if (i == 2) check("y0_zout", 768'(res.z), 768'(0));
    end

    zi  = powm(gres.z, P - 256'd2);
    zi2 = mulm(zi, zi);
    check("g2_affine_x", 768'(mulm(gres.x, zi2)), 768'(G2X));
    check("g2_affine_y", 768'(mulm(gres.y, mulm(zi2, zi))), 768'(G2Y));

    u_a = P - 256'd1; u_b = 256'd1; u_sub = 1'b0; #1;
    check("unit_add_wrap", 768'(u_r), 768'(0));
    u_a = 256'd0; u_b = 256'd1; u_sub = 1'b1; #1;
    check("unit_sub_borrow", 768'(u_r), 768'(P - 256'd1));
    u_a = P - 256'd1; u_b = P - 256'd1; u_sub = 1'b0; #1;
    check("unit_add_max", 768'(u_r), 768'(P - 256'd2));

    lmin = 1; lmax = 8; rdy_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      jb_point_t pin;
      pin.x = rand_coord();
      pin.y = rand_coord();
      pin.z = rand_coord();
      run_job(pin, (n % 8 == 0) ? 10 : 0, res, lat, muls, mvs);
      check("rand_pt", 768'(res), 768'(dbl_ref(pin)));
    end

    // Abort during the step-5 multiply wait, then inject a stale response
    lmin = 8; lmax = 8; rdy_rand = 1'b0;
    @(negedge i_clk);
    k = 0;
    while (!o_p_rdy && k < 200) begin @(negedge i_clk); k++; end
    base_r  = req_cnt;
    i_p     = g;
    i_p_val = 1'b1;
    @(negedge i_clk);
    i_p_val = 1'b0;
    k = 0;
    while (req_cnt - base_r < 5 && k < 500) begin @(negedge i_clk); k++; end
    check("abort_reach_step5", 768'(req_cnt - base_r), 768'(5));
    @(negedge i_clk);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    check("abort_rst_flags", 768'({o_p_val, o_mul_val, o_p_rdy}), 768'(3'b001));
    check("abort_rst_p", 768'(o_p), 768'(0));
    check("abort_rst_ops", 768'({o_mul_a, o_mul_b}), 768'(0));
    i_rst = 1'b0;
    base_r = req_cnt;
    stale_req++;
    repeat (12) @(negedge i_clk);
    check("stale_ignored", 768'({o_p_val, o_mul_val, o_p_rdy}), 768'(3'b001));
    check("stale_no_req", 768'(req_cnt - base_r), 768'(0));
    lmin = 3; lmax = 3;
    run_job(g, 0, res, lat, muls, mvs);
    check("post_abort_p", 768'(res), 768'(dbl_ref(g)));
    check("post_abort_lat", 768'(lat), 768'(41));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
